// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared types for the multi-cycle core sequencer.
//   opcode_t  : opcode field of the instruction register
//   state_t   : sequencer state, also exported for observability
//   ALU_*     : encodings driven on ctrl_ALU_op
//   is_known_op() : true for the opcodes the sequencer knows how to run
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        ARITH  = 7'b0110011,
        BRANCH = 7'b1100011
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        ADDR,
        MEM,
        EXEC,
        WB,
        BRN,
        HALT
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Anything outside these four opcodes takes the illegal-instruction path.
    function automatic logic is_known_op(opcode_t op);
        return op inside {LOAD, STORE, ARITH, BRANCH};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the sequencer and the rest of the core.
//   Inputs to the sequencer : opcode, mem_ready, alu_zero
//   Control outputs         : imem_req, ir_w, pc_w, pc_src, ctrl_*
//   Status outputs          : state_o, retire_cnt, illegal_op, mem_err
// master = the sequencer, slave = datapath / memory side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    import multicycle_ctrl_pkg::*;

    opcode_t          opcode;
    logic             mem_ready;
    logic             alu_zero;

    logic             imem_req;
    logic             ir_w;
    logic             pc_w;
    logic             pc_src;
    logic [1:0]       ctrl_ALU_op;
    logic             ctrl_ALU_src;
    logic             ctrl_reg_w;
    logic             ctrl_mem_r;
    logic             ctrl_mem_w;
    logic             ctrl_mem_to_reg;

    state_t           state_o;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal_op;
    logic             mem_err;

    modport master (
        input  opcode, mem_ready, alu_zero,
        output imem_req, ir_w, pc_w, pc_src, ctrl_ALU_op, ctrl_ALU_src,
               ctrl_reg_w, ctrl_mem_r, ctrl_mem_w, ctrl_mem_to_reg,
               state_o, retire_cnt, illegal_op, mem_err
    );

    modport slave (
        output opcode, mem_ready, alu_zero,
        input  imem_req, ir_w, pc_w, pc_src, ctrl_ALU_op, ctrl_ALU_src,
               ctrl_reg_w, ctrl_mem_r, ctrl_mem_w, ctrl_mem_to_reg,
               state_o, retire_cnt, illegal_op, mem_err
    );

endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// ctrl_wait_timer
// Counts consecutive cycles spent waiting on a memory handshake.
//   clk, rst   : core clock, async active-high reset
//   clear_i    : restart the count (takes priority over en_i)
//   en_i       : this cycle is a waiting cycle
//   expired_o  : this waiting cycle is the MAX_WAIT-th in a row
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int         W     = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);
    localparam logic [W-1:0] LAST  = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count waiting cycles, saturating at the limit so the value can never
    // wrap back into the tolerated range.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != LIMIT) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of earlier waiting cycles, so the current
    // cycle is the last tolerated one when MAX_WAIT-1 are already behind us.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore sequencer stepping each instruction through
// FETCH -> DECODE -> (ADDR -> MEM | EXEC | BRN) -> (WB) -> FETCH.
//   clk, rst : core clock, async active-high reset (release synchronized)
//   bus      : multicycle_ctrl_if master (opcode/mem_ready/alu_zero in,
//              datapath controls, state, retire count and sticky errors out)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_if.master      bus
);
    import multicycle_ctrl_pkg::*;

    state_t           state_q;
    state_t           state_d;
    opcode_t          op_q;
    opcode_t          op_d;
    logic             run_q;
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;
    logic             illegal_q;
    logic             illegal_d;
    logic             mem_err_q;
    logic             mem_err_d;
    logic             retire;
    logic             wait_en;
    logic             wait_expired;
    logic             in_decode;

    // Release synchronizer: run_q drops with reset and rises on the first
    // clock edge after release. Until then the sequencer sits in FETCH with
    // every output forced low, so no request goes out mid-release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // A cycle counts as waiting only while a handshake is outstanding.
    assign wait_en   = run_q && (state_q == FETCH || state_q == MEM) && !bus.mem_ready;
    assign in_decode = run_q && (state_q == DECODE);

    ctrl_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_d != state_q),
        .en_i      (wait_en),
        .expired_o (wait_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The decode branch reads the live opcode because op_q
    // is only being loaded in that same cycle.
    always_comb begin
        state_d = state_q;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    if (bus.mem_ready) begin
                        state_d = DECODE;
                    end else if (wait_expired) begin
                        state_d = HALT;
                    end
                end
                DECODE: begin
                    case (bus.opcode)
                        LOAD, STORE: state_d = ADDR;
                        ARITH:       state_d = EXEC;
                        BRANCH:      state_d = BRN;
                        default:     state_d = FETCH;
                    endcase
                end
                ADDR:    state_d = MEM;
                MEM: begin
                    if (bus.mem_ready) begin
                        state_d = (op_q == LOAD) ? WB : FETCH;
                    end else if (wait_expired) begin
                        state_d = HALT;
                    end
                end
                EXEC:    state_d = WB;
                WB:      state_d = FETCH;
                BRN:     state_d = FETCH;
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    // Output decode. Everything defaults low, and stays low while the reset
    // release is still being synchronized. retire marks the cycle that
    // commits an instruction; it coincides with pc_w except on the illegal
    // path, where the PC advances without retiring anything.
    always_comb begin
        bus.imem_req        = 1'b0;
        bus.ir_w            = 1'b0;
        bus.pc_w            = 1'b0;
        bus.pc_src          = 1'b0;
        bus.ctrl_ALU_op     = ALU_ADD;
        bus.ctrl_ALU_src    = 1'b0;
        bus.ctrl_reg_w      = 1'b0;
        bus.ctrl_mem_r      = 1'b0;
        bus.ctrl_mem_w      = 1'b0;
        bus.ctrl_mem_to_reg = 1'b0;
        retire              = 1'b0;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_w     = bus.mem_ready;
                end
                DECODE: begin
                    bus.pc_w = !is_known_op(bus.opcode);
                end
                ADDR: begin
                    bus.ctrl_ALU_op  = ALU_ADD;
                    bus.ctrl_ALU_src = 1'b1;
                end
                MEM: begin
                    bus.ctrl_ALU_op  = ALU_ADD;
                    bus.ctrl_ALU_src = 1'b1;
                    bus.ctrl_mem_r   = (op_q == LOAD);
                    bus.ctrl_mem_w   = (op_q == STORE);
                    if (op_q == STORE && bus.mem_ready) begin
                        bus.pc_w = 1'b1;
                        retire   = 1'b1;
                    end
                end
                EXEC: begin
                    bus.ctrl_ALU_op  = ALU_FUNCT;
                    bus.ctrl_ALU_src = 1'b0;
                end
                WB: begin
                    bus.ctrl_reg_w      = 1'b1;
                    bus.ctrl_mem_to_reg = (op_q == LOAD);
                    bus.pc_w            = 1'b1;
                    retire              = 1'b1;
                end
                BRN: begin
                    bus.ctrl_ALU_op = ALU_CMP;
                    bus.pc_w        = 1'b1;
                    bus.pc_src      = bus.alu_zero;
                    retire          = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next values for the opcode latch, retire counter and sticky flags.
    // The retire counter wraps naturally at CNT_W bits.
    always_comb begin
        op_d      = in_decode ? bus.opcode : op_q;
        retire_d  = retire_q + {{(CNT_W-1){1'b0}}, retire};
        illegal_d = illegal_q | (in_decode && !is_known_op(bus.opcode));
        mem_err_d = mem_err_q | wait_expired;
    end

    // Opcode latch, retire counter and sticky error flags; only reset clears
    // the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= opcode_t'(7'd0);
            retire_q  <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.retire_cnt = retire_q;
    assign bus.illegal_op = illegal_q;
    assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Drives instructions through the sequencer and compares every cycle against
// an expected trace built from the instruction-level rules (phase list per
// opcode, waits per handshake, retire/illegal/timeout bookkeeping).
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    typedef struct packed {
        state_t     st;
        logic       imem;
        logic       irw;
        logic       pcw;
        logic       pcsrc;
        logic       regw;
        logic       memr;
        logic       memw;
        logic       m2r;
        logic [1:0] aluop;
        logic       alusrc;
    } exp_t;

    typedef struct {
        exp_t e;
        logic ready;
        logic zero;
        logic decode;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   retireModel  = 0;
    logic illegalModel = 1'b0;
    logic memErrModel  = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic isKnown(opcode_t op);
        return (op == LOAD) || (op == STORE) || (op == ARITH) || (op == BRANCH);
    endfunction

    function automatic exp_t blank(state_t st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.st     = bus.state_o;
        o.imem   = bus.imem_req;
        o.irw    = bus.ir_w;
        o.pcw    = bus.pc_w;
        o.pcsrc  = bus.pc_src;
        o.regw   = bus.ctrl_reg_w;
        o.memr   = bus.ctrl_mem_r;
        o.memw   = bus.ctrl_mem_w;
        o.m2r    = bus.ctrl_mem_to_reg;
        o.aluop  = bus.ctrl_ALU_op;
        o.alusrc = bus.ctrl_ALU_src;
        return o;
    endfunction

    function automatic step_t newStep(state_t st, logic ready);
        step_t s;
        s.e      = blank(st);
        s.ready  = ready;
        s.zero   = 1'($urandom);
        s.decode = 1'b0;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready, input opcode_t op, input logic zero);
        bus.mem_ready = ready;
        bus.opcode    = op;
        bus.alu_zero  = zero;
    endtask

    task automatic checkStatus(input string name);
        checkOutput({name, ".retire"}, 32'(bus.retire_cnt), 32'(retireModel));
        checkOutput({name, ".illegal"}, 32'(bus.illegal_op), 32'(illegalModel));
        checkOutput({name, ".memerr"}, 32'(bus.mem_err), 32'(memErrModel));
    endtask

    // Builds the expected cycle trace of one instruction from its phases,
    // then plays it: fw fetch waits, mw data-memory waits, zeroBrn is the
    // alu_zero value presented in the branch phase.
    task automatic runInstr(input opcode_t op, input int fw, input int mw,
                            input logic zeroBrn, input string name);
        step_t plan[$];
        step_t s;
        logic  known;
        known = isKnown(op);
        for (int i = 0; i < fw; i++) begin
            s = newStep(FETCH, 1'b0);
            s.e.imem = 1'b1;
            plan.push_back(s);
        end
        s = newStep(FETCH, 1'b1);
        s.e.imem = 1'b1;
        s.e.irw  = 1'b1;
        plan.push_back(s);
        s = newStep(DECODE, 1'($urandom));
        s.decode = 1'b1;
        s.e.pcw  = !known;
        plan.push_back(s);
        if (op == LOAD || op == STORE) begin
            s = newStep(ADDR, 1'($urandom));
            s.e.alusrc = 1'b1;
            plan.push_back(s);
            for (int i = 0; i <= mw; i++) begin
                s = newStep(MEM, i == mw);
                s.e.alusrc = 1'b1;
                s.e.memr   = (op == LOAD);
                s.e.memw   = (op == STORE);
                s.e.pcw    = (op == STORE) && (i == mw);
                plan.push_back(s);
            end
            if (op == LOAD) begin
                s = newStep(WB, 1'($urandom));
                s.e.regw = 1'b1;
                s.e.m2r  = 1'b1;
                s.e.pcw  = 1'b1;
                plan.push_back(s);
            end
        end else if (op == ARITH) begin
            s = newStep(EXEC, 1'($urandom));
            s.e.aluop = 2'b10;
            plan.push_back(s);
            s = newStep(WB, 1'($urandom));
            s.e.regw = 1'b1;
            s.e.pcw  = 1'b1;
            plan.push_back(s);
        end else if (op == BRANCH) begin
            s = newStep(BRN, 1'($urandom));
            s.e.aluop = 2'b01;
            s.e.pcw   = 1'b1;
            s.zero    = zeroBrn;
            s.e.pcsrc = zeroBrn;
            plan.push_back(s);
        end
        foreach (plan[i]) begin
            applyStimulus(plan[i].ready,
                          plan[i].decode ? op : opcode_t'(7'($urandom)),
                          plan[i].zero);
            @(negedge clk);
            checkOutput($sformatf("%s.cyc%0d", name, i), 32'(observe()), 32'(plan[i].e));
            @(posedge clk);
            #1;
        end
        if (known) begin
            retireModel = (retireModel + 1) % (1 << CNT_W);
        end else begin
            illegalModel = 1'b1;
        end
        checkStatus(name);
    endtask

    initial begin
        exp_t    e;
        opcode_t op;
        int      k;

        applyStimulus(1'b1, ARITH, 1'b0);

        // Held in reset: idle outputs, FETCH, cleared counters.
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset.outs", 32'(observe()), 32'(blank(FETCH)));
            checkStatus("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release.sync", 32'(observe()), 32'(blank(FETCH)));
        @(posedge clk);
        #1;

        // Directed instructions.
        runInstr(ARITH, 0, 0, 1'b0, "arith");
        runInstr(LOAD, 0, 3, 1'b0, "load_w3");
        runInstr(STORE, 0, 0, 1'b0, "store");
        runInstr(BRANCH, 0, 0, 1'b1, "brn_taken");
        runInstr(BRANCH, 0, 0, 1'b0, "brn_not");
        runInstr(opcode_t'(7'h7F), 0, 0, 1'b0, "illegal");
        runInstr(ARITH, MAX_WAIT - 1, 0, 1'b0, "fetch_maxwait");
        runInstr(LOAD, 10, MAX_WAIT - 1, 1'b0, "wait_clear");

        // Randomized instruction mix; retire count wraps at CNT_W bits.
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 4);
            case (k)
                0:       op = LOAD;
                1:       op = STORE;
                2:       op = ARITH;
                3:       op = BRANCH;
                default: op = opcode_t'(7'($urandom));
            endcase
            runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                     $sformatf("rnd%0d", n));
        end

        // Reset arriving while a store is waiting in MEM.
        applyStimulus(1'b1, STORE, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, STORE, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        e        = blank(MEM);
        e.alusrc = 1'b1;
        e.memw   = 1'b1;
        checkOutput("midmem.before", 32'(observe()), 32'(e));
        #2;
        rst = 1'b1;
        #1;
        retireModel  = 0;
        illegalModel = 1'b0;
        checkOutput("midmem.async", 32'(observe()), 32'(blank(FETCH)));
        checkStatus("midmem");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, ARITH, 1'b0);
        @(negedge clk);
        checkOutput("midmem.sync", 32'(observe()), 32'(blank(FETCH)));
        @(posedge clk);
        #1;
        runInstr(ARITH, 0, 0, 1'b0, "after_reset");

        // Fetch timeout: fifteen low cycles, then HALT with mem_err set.
        e      = blank(FETCH);
        e.imem = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            applyStimulus(1'b0, opcode_t'(7'($urandom)), 1'($urandom));
            @(negedge clk);
            checkOutput($sformatf("timeout.wait%0d", i), 32'(observe()), 32'(e));
            @(posedge clk);
            #1;
        end
        memErrModel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ARITH, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("halt%0d", i), 32'(observe()), 32'(blank(HALT)));
            checkStatus("halt");
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencer for the multi-cycle core variant. It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake. It also exposes the retired-instruction count and sticky error flags to the power-modeling counters.

Parameters:
CNT_W, 32, width of retire_cnt (wraps modulo 2^CNT_W)
MAX_WAIT, 15, consecutive mem_ready-low cycles tolerated in FETCH/MEM before timeout

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
opcode  in  opcode_t  opcode field of IR; sampled in DECODE only
mem_ready  in  1  memory handshake completion (imem in FETCH, dmem in MEM)
alu_zero  in  1  ALU zero flag; branch-taken condition
imem_req  out  1  instruction fetch request
ir_w  out  1  IR write enable
pc_w  out  1  PC write enable
pc_src  out  1  0 = PC+4, 1 = branch target
ctrl_ALU_op  out  2  00 add, 01 compare, 10 funct-decoded
ctrl_ALU_src  out  1  1 = immediate operand
ctrl_reg_w  out  1  register-file write
ctrl_mem_r  out  1  data-memory read request
ctrl_mem_w  out  1  data-memory write request
ctrl_mem_to_reg  out  1  writeback source: 1 = memory data
state_o  out  state_t  current state (observability)
retire_cnt  out  CNT_W  instructions retired since reset
illegal_op  out  1  sticky: unknown opcode decoded
mem_err  out  1  sticky: handshake timeout

Behaviour:
- Reset (async, rst=1): state=FETCH; retire_cnt, wait counter, op_q, illegal_op and mem_err clear to 0. Any in-flight request is dropped. Release is synchronized internally. The first imem_req is asserted on the first clk edge after release.
- All outputs default to 0. Outputs are decoded from state and op_q. ir_w and pc_w are additionally gated by mem_ready where noted.
- FETCH: imem_req=1.
  - mem_ready=1: ir_w=1, go to DECODE.
  - Otherwise stay and increment wait counter.
- DECODE: op_q<=opcode.
  - LOAD or STORE -> ADDR.
  - ARITH -> EXEC.
  - BRANCH -> BRN.
  - Other -> set illegal_op, pc_w=1, pc_src=0, go to FETCH, no retire.
- ADDR: ALU_op=00, ALU_src=1, go to MEM.
- MEM: ALU_op=00, ALU_src=1. mem_r=1 if op_q=LOAD; mem_w=1 if op_q=STORE. Held stable until mem_ready.
  - LOAD with mem_ready -> WB.
  - STORE with mem_ready: pc_w=1, retire, go to FETCH.
- EXEC: ALU_op=10, ALU_src=0, go to WB.
- WB: reg_w=1, mem_to_reg=(op_q==LOAD), pc_w=1, pc_src=0, retire, go to FETCH.
- BRN: ALU_op=01, ALU_src=0, pc_w=1, pc_src=alu_zero, retire, go to FETCH.
- Latency with mem_ready tied high: BRANCH 3 cycles, ARITH 4, STORE 4, LOAD 5. Each mem_ready-low cycle adds 1.
- Wait counter: clears on every state change. When it reaches MAX_WAIT with mem_ready still low: set mem_err, go to HALT.
- HALT: all control outputs 0; stays until reset.
- Retire: retire_cnt+1 in the same cycle pc_w is asserted, except on the illegal path. Wraps from all-ones to 0.
- mem_ready outside FETCH/MEM is ignored.
- illegal_op and mem_err clear only on reset.

Decomposition:
- Shared core package:
  - opcode_t (existing enumeration)
  - new state_t {FETCH, DECODE, ADDR, MEM, EXEC, WB, BRN, HALT}
  - ALU_op encoding constants (ALU_ADD=2'b00, ALU_CMP=2'b01, ALU_FUNCT=2'b10)
- One sub-module, ctrl_wait_timer: the MAX_WAIT counter, with clear, count-enable and expired ports.

Test Plan:
- ARITH with mem_ready=1: state sequence FETCH, DECODE, EXEC, WB. reg_w=1 in WB only; retire_cnt 0->1 after 4 cycles.
- LOAD with dmem mem_ready low for 3 cycles: mem_r held for 4 cycles in MEM. WB has mem_to_reg=1; total 8 cycles.
- BRANCH with alu_zero=1: pc_w=1 and pc_src=1 in BRN. With alu_zero=0: pc_src=0. Both retire.
- Unknown opcode 7'b1111111: illegal_op=1, pc_w=1 in DECODE, retire_cnt unchanged, next state FETCH.
- mem_ready held low in FETCH: mem_err rises after 15 waiting cycles, state HALT, imem_req=0 thereafter.
- rst asserted mid-MEM with mem_w=1: outputs drop to 0 asynchronously, counters clear, FETCH resumes after release.
